// File: rtl/edge_det_pkg.sv
// Shared mode encoding and sizing helpers for the multi-channel edge detector.
package edge_det_pkg;

   // Per-channel edge selection; bit 0 enables rising edges, bit 1 falling edges.
   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   // Width of a counter that must hold values up to 'cycles' (never narrower than 1 bit).
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One detector channel: input synchroniser, glitch filter, mode match and event pulse.
module edge_det_chan
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic [1:0] mode,
   output logic       exp_next,
   output logic       exp_out,
   output logic       level_out
);

   localparam int            CW       = cnt_width(FILTER_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CW-1:0]          cnt;
   logic                   accept;
   mode_e                  mode_sel;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain: stage 0 samples the raw pin, the last stage feeds the filter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= a;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   // Edge acceptance and mode match, evaluated on the current filter state.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      exp_next = 1'b0;
      mode_sel = mode_e'(mode);
      accept   = (s != level_out) && (cnt == CNT_LAST);
      if (accept) begin
         case (mode_sel)
            MODE_RISE: exp_next = s;
            MODE_FALL: exp_next = ~s;
            MODE_BOTH: exp_next = 1'b1;
            default:   exp_next = 1'b0;
         endcase
      end
   end

   // Glitch filter: a changed level must persist FILTER_CYCLES samples before it is adopted.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         level_out <= 1'b0;
         exp_out   <= 1'b0;
      end else begin
         exp_out <= exp_next;
         if (s == level_out) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level_out <= s;
            cnt       <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: per-channel detectors plus sticky pending flags and irq.
module edge_detector_multi
   import edge_det_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   a,
   input  logic [2*WIDTH-1:0] mode,
   input  logic [WIDTH-1:0]   clr,
   output logic [WIDTH-1:0]   exp_out,
   output logic [WIDTH-1:0]   level_out,
   output logic [WIDTH-1:0]   pending,
   output logic               irq
);

   logic [WIDTH-1:0] exp_next;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      edge_det_chan #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .a        (a[i]),
         .mode     (mode[2*i +: 2]),
         .exp_next (exp_next[i]),
         .exp_out  (exp_out[i]),
         .level_out(level_out[i])
      );
   end

   // Sticky pending flags: a new event sets the flag on the same edge as its pulse and wins over clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr) | exp_next;
      end
   end

   assign irq = |pending;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi: default instance plus a minimal-parameter instance,
// a sliding-window reference model compared every cycle, and literal spot checks.
module tb_edge_detector_multi;
   import edge_det_pkg::*;

   localparam int HMAX = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  a;
   logic [15:0] mode;
   logic [7:0]  clr;
   logic [7:0]  a_exp, a_lvl, a_pnd;
   logic        a_irq;

   logic        b_reset;
   logic [0:0]  b_a;
   logic [1:0]  b_mode;
   logic [0:0]  b_clr;
   logic [0:0]  b_exp, b_lvl, b_pnd;
   logic        b_irq;

   int cmp_count = 0;
   int err_count = 0;

   always #5 clk = ~clk;

   edge_detector_multi #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut_a (
      .clk(clk), .reset(reset), .a(a), .mode(mode), .clr(clr),
      .exp_out(a_exp), .level_out(a_lvl), .pending(a_pnd), .irq(a_irq)
   );

   edge_detector_multi #(.WIDTH(1), .SYNC_STAGES(1), .FILTER_CYCLES(1)) dut_b (
      .clk(clk), .reset(b_reset), .a(b_a), .mode(b_mode), .clr(b_clr),
      .exp_out(b_exp), .level_out(b_lvl), .pending(b_pnd), .irq(b_irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   // Each instance keeps the history of raw samples since reset. The synchronised value seen at
   // post-reset edge k is the raw sample taken SYNC edges earlier; an edge is accepted at edge t
   // when the last FILTER synchronised values all differ from the current filtered level.
   int  sync_p [2] = '{2, 1};
   int  filt_p [2] = '{4, 1};
   int  wid_p  [2] = '{8, 1};
   bit  hist   [2][8][HMAX];
   int  n_hist [2];
   bit  m_lvl  [2][8];
   bit  m_exp  [2][8];
   bit  m_pnd  [2][8];
   bit  model_ready = 1'b0;

   function automatic bit s_at(input int d, input int ch, input int k);
      int idx;
      idx = k - sync_p[d] - 1;
      if (idx < 0) return 1'b0;
      return hist[d][ch][idx];
   endfunction

   task automatic model_step(input int d, input logic rst, input logic [7:0] av,
                             input logic [15:0] mv, input logic [7:0] cv);
      int  t;
      bit  acc;
      logic [1:0] m;
      if (rst) begin
         n_hist[d] = 0;
         for (int ch = 0; ch < 8; ch++) begin
            m_lvl[d][ch] = 1'b0;
            m_exp[d][ch] = 1'b0;
            m_pnd[d][ch] = 1'b0;
         end
      end else begin
         if (n_hist[d] < HMAX) begin
            for (int ch = 0; ch < 8; ch++) hist[d][ch][n_hist[d]] = av[ch];
            n_hist[d]++;
         end
         t = n_hist[d];
         for (int ch = 0; ch < wid_p[d]; ch++) begin
            acc = 1'b1;
            for (int j = 0; j < filt_p[d]; j++) begin
               if (s_at(d, ch, t - j) == m_lvl[d][ch]) acc = 1'b0;
            end
            m_exp[d][ch] = 1'b0;
            if (acc) begin
               m_lvl[d][ch] = ~m_lvl[d][ch];
               m = mv[2*ch +: 2];
               if (m_lvl[d][ch]) m_exp[d][ch] = (m == MODE_RISE) || (m == MODE_BOTH);
               else              m_exp[d][ch] = (m == MODE_FALL) || (m == MODE_BOTH);
            end
            m_pnd[d][ch] = (m_pnd[d][ch] & ~cv[ch]) | m_exp[d][ch];
         end
      end
   endtask

   // Model advances on every active edge using the inputs that edge samples.
   always @(posedge clk) begin
      model_step(0, reset, a, mode, clr);
      model_step(1, b_reset, {7'b0, b_a}, {14'b0, b_mode}, {7'b0, b_clr});
      model_ready = 1'b1;
   end

   // Compare process: every cycle, both instances, away from the active edge.
   always @(negedge clk) begin
      logic [7:0] e_exp, e_lvl, e_pnd;
      if (model_ready) begin
         for (int ch = 0; ch < 8; ch++) begin
            e_exp[ch] = m_exp[0][ch];
            e_lvl[ch] = m_lvl[0][ch];
            e_pnd[ch] = m_pnd[0][ch];
         end
         check("model_a_exp_out",   32'(a_exp), 32'(e_exp));
         check("model_a_level_out", 32'(a_lvl), 32'(e_lvl));
         check("model_a_pending",   32'(a_pnd), 32'(e_pnd));
         check("model_a_irq",       32'(a_irq), 32'(|e_pnd));
         check("model_b_exp_out",   32'(b_exp), 32'(m_exp[1][0]));
         check("model_b_level_out", 32'(b_lvl), 32'(m_lvl[1][0]));
         check("model_b_pending",   32'(b_pnd), 32'(m_pnd[1][0]));
         check("model_b_irq",       32'(b_irq), 32'(m_pnd[1][0]));
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      reset = 1'b1; a = '0; mode = '0; clr = '0;
      b_reset = 1'b1; b_a = '0; b_mode = MODE_OFF; b_clr = '0;
      tick(3);
      check("reset_exp",   32'(a_exp), 32'h0);
      check("reset_level", 32'(a_lvl), 32'h0);
      check("reset_pend",  32'(a_pnd), 32'h0);
      check("reset_irq",   32'(a_irq), 32'h0);
      reset = 1'b0;

      // Idle with all inputs low: nothing moves.
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("idle_exp",   32'(a_exp), 32'h0);
         check("idle_level", 32'(a_lvl), 32'h0);
         check("idle_pend",  32'(a_pnd), 32'h0);
         check("idle_irq",   32'(a_irq), 32'h0);
      end

      // Input held high through reset is reported as a rise 6 cycles after release.
      reset = 1'b1; a[4] = 1'b1; mode[9:8] = MODE_RISE;
      tick(3);
      check("held_reset_level", 32'(a_lvl[4]), 32'h0);
      reset = 1'b0;
      tick(5);
      check("held_rise_early",  32'(a_exp[4]), 32'h0);
      tick(1);
      check("held_rise_pulse",  32'(a_exp[4]), 32'h1);
      check("held_rise_level",  32'(a_lvl[4]), 32'h1);
      check("held_rise_pend",   32'(a_pnd[4]), 32'h1);
      check("held_rise_irq",    32'(a_irq),    32'h1);
      tick(1);
      check("held_rise_one_cycle", 32'(a_exp[4]), 32'h0);
      clr[4] = 1'b1;
      tick(1);
      clr = '0;
      check("held_clr_pend", 32'(a_pnd[4]), 32'h0);
      check("held_clr_irq",  32'(a_irq),    32'h0);

      mode[1:0] = MODE_BOTH; mode[3:2] = MODE_BOTH;
      mode[5:4] = MODE_FALL; mode[7:6] = MODE_OFF;
      tick(2);

      // Clean edges on channel 0, mode both.
      a[0] = 1'b1;
      tick(5);
      check("ch0_rise_early_exp", 32'(a_exp[0]), 32'h0);
      check("ch0_rise_early_lvl", 32'(a_lvl[0]), 32'h0);
      tick(1);
      check("ch0_rise_exp",  32'(a_exp[0]), 32'h1);
      check("ch0_rise_lvl",  32'(a_lvl[0]), 32'h1);
      check("ch0_rise_pend", 32'(a_pnd[0]), 32'h1);
      check("ch0_rise_irq",  32'(a_irq),    32'h1);
      tick(1);
      check("ch0_rise_one_cycle", 32'(a_exp[0]), 32'h0);
      tick(3);
      a[0] = 1'b0;
      tick(5);
      check("ch0_fall_early_exp", 32'(a_exp[0]), 32'h0);
      check("ch0_fall_early_lvl", 32'(a_lvl[0]), 32'h1);
      tick(1);
      check("ch0_fall_exp", 32'(a_exp[0]), 32'h1);
      check("ch0_fall_lvl", 32'(a_lvl[0]), 32'h0);
      tick(1);
      check("ch0_fall_one_cycle", 32'(a_exp[0]), 32'h0);

      // Glitch rejection on channel 1: 3-cycle pulse is discarded, 4-cycle pulse is kept.
      a[1] = 1'b1;
      tick(3);
      a[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("glitch_exp",  32'(a_exp[1]), 32'h0);
         check("glitch_lvl",  32'(a_lvl[1]), 32'h0);
         check("glitch_pend", 32'(a_pnd[1]), 32'h0);
      end
      a[1] = 1'b1;
      tick(4);
      a[1] = 1'b0;
      tick(2);
      check("pulse4_rise_exp", 32'(a_exp[1]), 32'h1);
      check("pulse4_rise_lvl", 32'(a_lvl[1]), 32'h1);
      tick(1);
      check("pulse4_rise_one_cycle", 32'(a_exp[1]), 32'h0);
      tick(3);
      check("pulse4_fall_exp", 32'(a_exp[1]), 32'h1);
      check("pulse4_fall_lvl", 32'(a_lvl[1]), 32'h0);

      // Mode filtering: channel 2 fall-only, channel 3 off.
      a[2] = 1'b1; a[3] = 1'b1;
      tick(6);
      check("mode_rise_exp",  32'(a_exp[3:2]), 32'h0);
      check("mode_rise_lvl",  32'(a_lvl[3:2]), 32'h3);
      check("mode_rise_pend", 32'(a_pnd[3:2]), 32'h0);
      tick(4);
      a[2] = 1'b0; a[3] = 1'b0;
      tick(6);
      check("mode_fall_exp",  32'(a_exp[3:2]), 32'h1);
      check("mode_fall_lvl",  32'(a_lvl[3:2]), 32'h0);
      check("mode_fall_pend", 32'(a_pnd[3:2]), 32'h1);

      // Pending: set wins over a coincident clear, clear on the next cycle takes effect.
      clr = '1;
      tick(1);
      clr = '0;
      check("clr_all_pend", 32'(a_pnd), 32'h0);
      check("clr_all_irq",  32'(a_irq), 32'h0);
      a[0] = 1'b1;
      tick(5);
      clr[0] = 1'b1;
      tick(1);
      check("set_wins_exp",  32'(a_exp[0]), 32'h1);
      check("set_wins_pend", 32'(a_pnd[0]), 32'h1);
      check("set_wins_irq",  32'(a_irq),    32'h1);
      tick(1);
      check("clr_next_pend", 32'(a_pnd[0]), 32'h0);
      check("clr_next_irq",  32'(a_irq),    32'h0);
      clr = '0;

      // Mode changes on a stable level produce no event.
      mode[1:0] = MODE_OFF;
      tick(1);
      mode[1:0] = MODE_RISE;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("mode_change_no_exp", 32'(a_exp), 32'h0);
      end

      // Reset mid-filter on channel 5: the partial count is lost; high inputs re-report later.
      a[5] = 1'b1; mode[11:10] = MODE_BOTH;
      tick(3);
      reset = 1'b1;
      tick(1);
      check("midreset_lvl",  32'(a_lvl), 32'h0);
      check("midreset_pend", 32'(a_pnd), 32'h0);
      check("midreset_exp",  32'(a_exp), 32'h0);
      reset = 1'b0;
      tick(5);
      check("rerise_early_exp", 32'(a_exp), 32'h0);
      tick(1);
      check("rerise_exp",  32'(a_exp), 32'h31);
      check("rerise_pend", 32'(a_pnd), 32'h31);
      clr = '1;
      tick(1);
      clr = '0;

      // Minimal-parameter instance: 2-cycle latency, reset mid-filter suppresses the event.
      b_reset = 1'b0; b_mode = MODE_BOTH;
      tick(2);
      b_a = 1'b1;
      tick(1);
      check("sweep_rise_early", 32'(b_exp), 32'h0);
      tick(1);
      check("sweep_rise_exp",  32'(b_exp), 32'h1);
      check("sweep_rise_lvl",  32'(b_lvl), 32'h1);
      check("sweep_rise_pend", 32'(b_pnd), 32'h1);
      check("sweep_rise_irq",  32'(b_irq), 32'h1);
      tick(1);
      check("sweep_rise_one_cycle", 32'(b_exp), 32'h0);
      b_a = 1'b0;
      tick(1);
      check("sweep_midfilter_exp", 32'(b_exp), 32'h0);
      check("sweep_midfilter_lvl", 32'(b_lvl), 32'h1);
      b_reset = 1'b1;
      tick(1);
      check("sweep_reset_exp",  32'(b_exp), 32'h0);
      check("sweep_reset_lvl",  32'(b_lvl), 32'h0);
      check("sweep_reset_pend", 32'(b_pnd), 32'h0);
      check("sweep_reset_irq",  32'(b_irq), 32'h0);
      b_reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("sweep_after_reset_exp",  32'(b_exp), 32'h0);
         check("sweep_after_reset_pend", 32'(b_pnd), 32'h0);
      end

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
